// File: rtl/pipe_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_top (with pipe_imem, pipe_regfile, pipe_dmem)     |
// | Description : 5-stage in-order RV32I-subset core with forwarding,    |
// |               load-use stall and branch flush resolved in EX.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

// Instruction memory: combinational word read, out-of-range fetches a NOP.
module pipe_imem #(
  parameter int DEPTH = 256
) (
  input  wire logic                     clk,
  input  wire logic                     load_en,
  input  wire logic [$clog2(DEPTH)-1:0] load_idx,
  input  wire logic [31:0]              load_data,
  input  wire logic [29:0]              word_addr,
  output logic [31:0]                   instr
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] mem [0:DEPTH-1];

  // Program load port; contents are never cleared so they survive reset.
  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
  end

  assign instr = (word_addr < 30'(DEPTH)) ? mem[word_addr[$clog2(DEPTH)-1:0]] : NOP;
endmodule

// Register file: write in WB, reads bypass a same-cycle WB write.
module pipe_regfile (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [4:0]  ra1,
  input  wire logic [4:0]  ra2,
  output logic [31:0]      rd1,
  output logic [31:0]      rd2,
  input  wire logic        we,
  input  wire logic [4:0]  wa,
  input  wire logic [31:0] wd
);
  logic [31:0] regs [0:31];

  // Clear on reset; writes to x0 are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // x0 reads zero; a WB write to the same register is seen in the same cycle.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : (we && wa == ra1) ? wd : regs[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : (we && wa == ra2) ? wd : regs[ra2];
  end
endmodule

// Data memory: synchronous write, combinational read, index wraps by depth.
module pipe_dmem #(
  parameter int DEPTH = 256
) (
  input  wire logic        clk,
  input  wire logic        we,
  input  wire logic [29:0] word_addr,
  input  wire logic [31:0] wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [0:DEPTH-1];
  logic [$clog2(DEPTH)-1:0] idx;

  assign idx   = $clog2(DEPTH)'(word_addr % 30'(DEPTH));
  assign rdata = mem[idx];

  // Store lands at the edge that ends the MEM stage.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end
endmodule

module pipe_top #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input wire logic clk,
  input wire logic rst_n   // active-high despite the suffix
);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI    = 7'b0110111, OP_AUIPC = 7'b0010111,
                          OP_JAL    = 7'b1101111, OP_JALR  = 7'b1100111,
                          OP_BRANCH = 7'b1100011, OP_LOAD  = 7'b0000011,
                          OP_STORE  = 7'b0100011, OP_IMM   = 7'b0010011,
                          OP_REG    = 7'b0110011;

  logic [31:0] pc, if_instr;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_instr;
  logic        idex_valid;
  logic [31:0] idex_pc, idex_instr, idex_rv1, idex_rv2;
  logic        exmem_regwrite, exmem_memread, exmem_memwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result, exmem_store_data;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_value;

  logic [31:0] id_rv1, id_rv2, dmem_rdata, mem_value;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_out, ex_result, ex_target;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal, ex_live, ex_regwrite, ex_memread, ex_memwrite, ex_taken, br_cond, load_use;

  wire logic [4:0] id_rs1 = ifid_instr[19:15];
  wire logic [4:0] id_rs2 = ifid_instr[24:20];
  wire logic [6:0] ex_op  = idex_instr[6:0];
  wire logic [2:0] ex_f3  = idex_instr[14:12];
  wire logic [6:0] ex_f7  = idex_instr[31:25];
  wire logic [4:0] ex_rd  = idex_instr[11:7];
  wire logic [4:0] ex_rs1 = idex_instr[19:15];
  wire logic [4:0] ex_rs2 = idex_instr[24:20];

  pipe_imem #(.DEPTH(IMEM_DEPTH)) INST1 (
    .clk(clk), .load_en(1'b0), .load_idx('0), .load_data(32'd0),
    .word_addr(pc[31:2]), .instr(if_instr));

  pipe_regfile RF1 (
    .clk(clk), .rst(rst_n), .ra1(id_rs1), .ra2(id_rs2), .rd1(id_rv1), .rd2(id_rv2),
    .we(memwb_regwrite), .wa(memwb_rd), .wd(memwb_value));

  pipe_dmem #(.DEPTH(DMEM_DEPTH)) DATA1 (
    .clk(clk), .we(exmem_memwrite), .word_addr(exmem_result[31:2]),
    .wdata(exmem_store_data), .rdata(dmem_rdata));

  // Value the MEM stage will retire; also the EX/MEM forwarding source.
  assign mem_value = exmem_memread ? dmem_rdata : exmem_result;

  // Immediate extraction for every format.
  always_comb begin
    imm_i = {{20{idex_instr[31]}}, idex_instr[31:20]};
    imm_s = {{20{idex_instr[31]}}, idex_instr[31:25], idex_instr[11:7]};
    imm_b = {{19{idex_instr[31]}}, idex_instr[31], idex_instr[7], idex_instr[30:25], idex_instr[11:8], 1'b0};
    imm_u = {idex_instr[31:12], 12'd0};
    imm_j = {{11{idex_instr[31]}}, idex_instr[31], idex_instr[19:12], idex_instr[20], idex_instr[30:21], 1'b0};
  end

  // Operand forwarding: most recent producer wins, x0 never forwards.
  always_comb begin
    fwd_a = idex_rv1;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == ex_rs1)      fwd_a = mem_value;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == ex_rs1) fwd_a = memwb_value;
    fwd_b = idex_rv2;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == ex_rs2)      fwd_b = mem_value;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == ex_rs2) fwd_b = memwb_value;
  end

  // Decode legality; anything unrecognised retires as a NOP.
  always_comb begin
    legal = 1'b0;
    case (ex_op)
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR:                  legal = (ex_f3 == 3'b000);
      OP_BRANCH:                legal = (ex_f3 != 3'b010) && (ex_f3 != 3'b011);
      OP_LOAD, OP_STORE:        legal = (ex_f3 == 3'b010);
      OP_IMM:   legal = (ex_f3 == 3'b001) ? (ex_f7 == 7'b0000000) :
                        (ex_f3 == 3'b101) ? (ex_f7 == 7'b0000000 || ex_f7 == 7'b0100000) : 1'b1;
      OP_REG:   legal = (ex_f7 == 7'b0000000) ||
                        (ex_f7 == 7'b0100000 && (ex_f3 == 3'b000 || ex_f3 == 3'b101));
      default:  legal = 1'b0;
    endcase
  end

  // ALU, branch condition, result select and redirect target.
  always_comb begin
    alu_b = (ex_op == OP_REG) ? fwd_b : imm_i;
    case (ex_f3)
      3'b000:  alu_out = (ex_op == OP_REG && ex_f7[5]) ? fwd_a - alu_b : fwd_a + alu_b;
      3'b001:  alu_out = fwd_a << alu_b[4:0];
      3'b010:  alu_out = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      3'b011:  alu_out = {31'd0, fwd_a < alu_b};
      3'b100:  alu_out = fwd_a ^ alu_b;
      3'b101:  alu_out = ex_f7[5] ? 32'($signed(fwd_a) >>> alu_b[4:0]) : fwd_a >> alu_b[4:0];
      3'b110:  alu_out = fwd_a | alu_b;
      default: alu_out = fwd_a & alu_b;
    endcase
    case (ex_f3)
      3'b000:  br_cond = (fwd_a == fwd_b);
      3'b001:  br_cond = (fwd_a != fwd_b);
      3'b100:  br_cond = $signed(fwd_a) < $signed(fwd_b);
      3'b101:  br_cond = $signed(fwd_a) >= $signed(fwd_b);
      3'b110:  br_cond = fwd_a < fwd_b;
      default: br_cond = fwd_a >= fwd_b;
    endcase
    case (ex_op)
      OP_LUI:          ex_result = imm_u;
      OP_AUIPC:        ex_result = idex_pc + imm_u;
      OP_JAL, OP_JALR: ex_result = idex_pc + 32'd4;
      OP_LOAD:         ex_result = fwd_a + imm_i;
      OP_STORE:        ex_result = fwd_a + imm_s;
      default:         ex_result = alu_out;
    endcase
    case (ex_op)
      OP_JAL:  ex_target = idex_pc + imm_j;
      OP_JALR: ex_target = (fwd_a + imm_i) & ~32'd1;
      default: ex_target = idex_pc + imm_b;
    endcase
    ex_live     = idex_valid && legal;
    ex_memread  = ex_live && ex_op == OP_LOAD;
    ex_memwrite = ex_live && ex_op == OP_STORE;
    ex_regwrite = ex_live && ex_rd != 5'd0 && ex_op != OP_BRANCH && ex_op != OP_STORE;
    ex_taken    = ex_live && (ex_op == OP_JAL || ex_op == OP_JALR || (ex_op == OP_BRANCH && br_cond));
    load_use    = ex_memread && ex_rd != 5'd0 && ifid_valid && (ex_rd == id_rs1 || ex_rd == id_rs2);
  end

  // PC and IF/ID: a taken redirect beats a stall; a stall holds both.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc <= RESET_PC; ifid_valid <= 1'b0; ifid_pc <= '0; ifid_instr <= NOP;
    end else if (ex_taken) begin
      pc <= ex_target; ifid_valid <= 1'b0; ifid_instr <= NOP;
    end else if (!load_use) begin
      pc <= pc + 32'd4; ifid_valid <= 1'b1; ifid_pc <= pc; ifid_instr <= if_instr;
    end
  end

  // ID/EX: bubble on reset, flush or load-use stall.
  always_ff @(posedge clk) begin
    if (rst_n || ex_taken || load_use) begin
      idex_valid <= 1'b0; idex_instr <= NOP;
    end else begin
      idex_valid <= ifid_valid; idex_pc <= ifid_pc; idex_instr <= ifid_instr;
      idex_rv1 <= id_rv1; idex_rv2 <= id_rv2;
    end
  end

  // EX/MEM: control bits cleared on reset so nothing retires.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      exmem_regwrite <= 1'b0; exmem_memread <= 1'b0; exmem_memwrite <= 1'b0;
    end else begin
      exmem_regwrite <= ex_regwrite; exmem_memread <= ex_memread; exmem_memwrite <= ex_memwrite;
      exmem_rd <= ex_rd; exmem_result <= ex_result; exmem_store_data <= fwd_b;
    end
  end

  // MEM/WB: carries the retiring value to the register file.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      memwb_regwrite <= 1'b0;
    end else begin
      memwb_regwrite <= exmem_regwrite; memwb_rd <= exmem_rd; memwb_value <= mem_value;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipe_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pipe_top                                            |
// | Description : Directed program tests for the pipe_top core.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pipe_top;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OPI = 7'b0010011;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] prog [0:63];
  int prog_len = 0;

  pipe_top dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Load prog[] into instruction memory and hold reset for two edges.
  // Returns #1 after the last reset edge with reset released; the next edge is E1.
  task automatic start_prog();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) dut.INST1.mem[i] = (i < prog_len) ? prog[i] : NOP;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic all_zero;
    @(posedge clk); #1 rst_n = 1'b1;
    step(2);
    checks++; if (dut.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", dut.pc, 32'h0); end
    checks++; if (dut.ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_ifid_valid got %b want 0", dut.ifid_valid); end
    checks++; if (dut.idex_valid !== 1'b0) begin errors++; $display("FAIL reset_idex_valid got %b want 0", dut.idex_valid); end
    checks++; if (dut.exmem_memwrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite got %b want 0", dut.exmem_memwrite); end
    all_zero = 1'b1;
    for (int i = 0; i < 32; i++) if (dut.RF1.regs[i] !== 32'd0) all_zero = 1'b0;
    checks++; if (all_zero !== 1'b1) begin errors++; $display("FAIL reset_regs got nonzero want all 0"); end
  endtask

  task automatic test_back_to_back();
    prog[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
    prog[1] = enc_i(12'd3, 5'd1, 3'b000, 5'd2, OPI);
    prog[2] = enc_r(7'b0000000, 5'd1, 5'd2, 3'b000, 5'd3);
    prog[3] = enc_r(7'b0100000, 5'd2, 5'd3, 3'b000, 5'd4);
    prog_len = 4;
    start_prog();
    step(7);
    checks++; if (dut.RF1.regs[3] !== 32'd13) begin errors++; $display("FAIL b2b_x3_at_E7 got %0d want 13", dut.RF1.regs[3]); end
    checks++; if (dut.RF1.regs[4] !== 32'd0) begin errors++; $display("FAIL b2b_x4_at_E7 got %0d want 0", dut.RF1.regs[4]); end
    step(1);
    checks++; if (dut.RF1.regs[4] !== 32'd5) begin errors++; $display("FAIL b2b_x4_at_E8 got %0d want 5", dut.RF1.regs[4]); end
    step(92);
    checks++; if (dut.RF1.regs[1] !== 32'd5) begin errors++; $display("FAIL b2b_x1 got %0d want 5", dut.RF1.regs[1]); end
    checks++; if (dut.RF1.regs[2] !== 32'd8) begin errors++; $display("FAIL b2b_x2 got %0d want 8", dut.RF1.regs[2]); end
  endtask

  task automatic test_double_hazard();
    prog[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OPI);
    prog[1] = enc_i(12'd1, 5'd1, 3'b000, 5'd1, OPI);
    prog[2] = enc_i(12'd1, 5'd1, 3'b000, 5'd1, OPI);
    prog[3] = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);
    prog_len = 4;
    start_prog();
    step(100);
    checks++; if (dut.RF1.regs[1] !== 32'd3) begin errors++; $display("FAIL dh_x1 got %0d want 3", dut.RF1.regs[1]); end
    checks++; if (dut.RF1.regs[2] !== 32'd6) begin errors++; $display("FAIL dh_x2 got %0d want 6", dut.RF1.regs[2]); end
  endtask

  task automatic test_load_use();
    prog[0] = enc_i(12'd42, 5'd0, 3'b000, 5'd5, OPI);
    prog[1] = enc_s(12'd8, 5'd5, 5'd0);
    prog[2] = enc_i(12'd8, 5'd0, 3'b010, 5'd6, 7'b0000011);
    prog[3] = enc_i(12'd1, 5'd6, 3'b000, 5'd7, OPI);
    prog_len = 4;
    start_prog();
    step(7);
    checks++; if (dut.RF1.regs[6] !== 32'd42) begin errors++; $display("FAIL lu_x6_at_E7 got %0d want 42", dut.RF1.regs[6]); end
    step(1);
    checks++; if (dut.RF1.regs[7] !== 32'd0) begin errors++; $display("FAIL lu_x7_at_E8 got %0d want 0", dut.RF1.regs[7]); end
    step(1);
    checks++; if (dut.RF1.regs[7] !== 32'd43) begin errors++; $display("FAIL lu_x7_at_E9 got %0d want 43", dut.RF1.regs[7]); end
    checks++; if (dut.DATA1.mem[2] !== 32'd42) begin errors++; $display("FAIL lu_dmem2 got %0d want 42", dut.DATA1.mem[2]); end
  endtask

  task automatic test_branch();
    prog[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OPI);
    prog[1] = enc_b(13'd8, 5'd1, 5'd1, 3'b000);
    prog[2] = enc_i(12'd99, 5'd0, 3'b000, 5'd2, OPI);
    prog[3] = enc_i(12'd7, 5'd0, 3'b000, 5'd3, OPI);
    prog_len = 4;
    start_prog();
    step(8);
    checks++; if (dut.RF1.regs[3] !== 32'd0) begin errors++; $display("FAIL beq_x3_at_E8 got %0d want 0", dut.RF1.regs[3]); end
    step(1);
    checks++; if (dut.RF1.regs[3] !== 32'd7) begin errors++; $display("FAIL beq_x3_at_E9 got %0d want 7", dut.RF1.regs[3]); end
    step(50);
    checks++; if (dut.RF1.regs[2] !== 32'd0) begin errors++; $display("FAIL beq_x2 got %0d want 0", dut.RF1.regs[2]); end
    prog[1] = enc_b(13'd8, 5'd1, 5'd1, 3'b001);
    start_prog();
    step(7);
    checks++; if (dut.RF1.regs[2] !== 32'd99) begin errors++; $display("FAIL bne_x2_at_E7 got %0d want 99", dut.RF1.regs[2]); end
    step(1);
    checks++; if (dut.RF1.regs[3] !== 32'd7) begin errors++; $display("FAIL bne_x3_at_E8 got %0d want 7", dut.RF1.regs[3]); end
  endtask

  task automatic test_jump_link();
    prog[0] = enc_j(21'd8, 5'd1);
    prog[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd9, OPI);
    prog[2] = enc_i(12'd5, 5'd0, 3'b000, 5'd0, OPI);
    prog[3] = enc_i(12'd3, 5'd0, 3'b000, 5'd12, OPI);
    prog_len = 4;
    start_prog();
    step(100);
    checks++; if (dut.RF1.regs[1] !== 32'd4) begin errors++; $display("FAIL jal_x1 got %0d want 4", dut.RF1.regs[1]); end
    checks++; if (dut.RF1.regs[9] !== 32'd0) begin errors++; $display("FAIL jal_x9 got %0d want 0", dut.RF1.regs[9]); end
    checks++; if (dut.RF1.regs[0] !== 32'd0) begin errors++; $display("FAIL x0_reg got %0d want 0", dut.RF1.regs[0]); end
    checks++; if (dut.RF1.regs[12] !== 32'd3) begin errors++; $display("FAIL x0_fwd_x12 got %0d want 3", dut.RF1.regs[12]); end
  endtask

  task automatic load_alu_prog();
    prog[0]  = {20'h80000, 5'd1, 7'b0110111};                   // lui x1,0x80000
    prog[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPI);         // addi x2,x0,-3
    prog[2]  = enc_i(12'h404, 5'd1, 3'b101, 5'd3, OPI);         // srai x3,x1,4
    prog[3]  = enc_i(12'h004, 5'd1, 3'b101, 5'd4, OPI);         // srli x4,x1,4
    prog[4]  = enc_i(12'h002, 5'd2, 3'b001, 5'd5, OPI);         // slli x5,x2,2
    prog[5]  = enc_r(7'd0, 5'd0, 5'd2, 3'b010, 5'd6);           // slt x6,x2,x0
    prog[6]  = enc_r(7'd0, 5'd0, 5'd2, 3'b011, 5'd7);           // sltu x7,x2,x0
    prog[7]  = enc_i(12'hFFF, 5'd0, 3'b011, 5'd8, OPI);         // sltiu x8,x0,-1
    prog[8]  = enc_i(12'h00F, 5'd2, 3'b100, 5'd9, OPI);         // xori x9,x2,15
    prog[9]  = enc_i(12'h5A5, 5'd0, 3'b110, 5'd10, OPI);        // ori x10,x0,0x5a5
    prog[10] = enc_i(12'h0F0, 5'd10, 3'b111, 5'd11, OPI);       // andi x11,x10,0xf0
    prog[11] = {20'h00001, 5'd12, 7'b0010111};                  // auipc x12,1
    prog[12] = enc_r(7'b0100000, 5'd2, 5'd0, 3'b000, 5'd13);    // sub x13,x0,x2
    prog[13] = enc_r(7'b0100000, 5'd13, 5'd1, 3'b101, 5'd14);   // sra x14,x1,x13
    prog[14] = enc_r(7'd0, 5'd13, 5'd1, 3'b101, 5'd15);         // srl x15,x1,x13
    prog[15] = enc_r(7'd0, 5'd13, 5'd13, 3'b001, 5'd16);        // sll x16,x13,x13
    prog[16] = enc_r(7'd0, 5'd13, 5'd6, 3'b110, 5'd17);         // or x17,x6,x13
    prog[17] = enc_r(7'd0, 5'd13, 5'd2, 3'b111, 5'd18);         // and x18,x2,x13
    prog[18] = enc_r(7'd0, 5'd13, 5'd2, 3'b100, 5'd19);         // xor x19,x2,x13
    prog[19] = enc_i(12'd5, 5'd2, 3'b010, 5'd20, OPI);          // slti x20,x2,5
    prog[20] = enc_b(13'd8, 5'd0, 5'd2, 3'b100);                // blt x2,x0,+8
    prog[21] = enc_i(12'd1, 5'd0, 3'b000, 5'd21, OPI);
    prog[22] = enc_b(13'd8, 5'd0, 5'd2, 3'b110);                // bltu x2,x0,+8
    prog[23] = enc_i(12'd1, 5'd0, 3'b000, 5'd22, OPI);
    prog[24] = enc_b(13'd8, 5'd0, 5'd2, 3'b111);                // bgeu x2,x0,+8
    prog[25] = enc_i(12'd1, 5'd0, 3'b000, 5'd23, OPI);
    prog[26] = enc_b(13'd8, 5'd2, 5'd0, 3'b101);                // bge x0,x2,+8
    prog[27] = enc_i(12'd1, 5'd0, 3'b000, 5'd24, OPI);
    prog[28] = enc_i(12'd125, 5'd0, 3'b000, 5'd26, OPI);        // addi x26,x0,125
    prog[29] = enc_i(12'd0, 5'd26, 3'b000, 5'd25, 7'b1100111);  // jalr x25,0(x26)
    prog[30] = enc_i(12'd1, 5'd0, 3'b000, 5'd27, OPI);
    prog[31] = enc_i(12'd7, 5'd0, 3'b000, 5'd28, OPI);
    prog[32] = enc_i(12'd1, 5'd0, 3'b000, 5'd29, 7'b0001011);   // custom-0: NOP
    prog[33] = enc_r(7'b0000001, 5'd13, 5'd13, 3'b000, 5'd30);  // mul: NOP
    prog_len = 34;
  endtask

  task automatic test_alu_ops();
    load_alu_prog();
    start_prog();
    step(120);
    checks++; if (dut.RF1.regs[1]  !== 32'h80000000) begin errors++; $display("FAIL lui got %h want 80000000", dut.RF1.regs[1]); end
    checks++; if (dut.RF1.regs[3]  !== 32'hF8000000) begin errors++; $display("FAIL srai got %h want f8000000", dut.RF1.regs[3]); end
    checks++; if (dut.RF1.regs[4]  !== 32'h08000000) begin errors++; $display("FAIL srli got %h want 08000000", dut.RF1.regs[4]); end
    checks++; if (dut.RF1.regs[5]  !== 32'hFFFFFFF4) begin errors++; $display("FAIL slli got %h want fffffff4", dut.RF1.regs[5]); end
    checks++; if (dut.RF1.regs[6]  !== 32'd1)        begin errors++; $display("FAIL slt got %h want 1", dut.RF1.regs[6]); end
    checks++; if (dut.RF1.regs[7]  !== 32'd0)        begin errors++; $display("FAIL sltu got %h want 0", dut.RF1.regs[7]); end
    checks++; if (dut.RF1.regs[8]  !== 32'd1)        begin errors++; $display("FAIL sltiu got %h want 1", dut.RF1.regs[8]); end
    checks++; if (dut.RF1.regs[9]  !== 32'hFFFFFFF2) begin errors++; $display("FAIL xori got %h want fffffff2", dut.RF1.regs[9]); end
    checks++; if (dut.RF1.regs[11] !== 32'h000000A0) begin errors++; $display("FAIL andi got %h want a0", dut.RF1.regs[11]); end
    checks++; if (dut.RF1.regs[12] !== 32'h0000102C) begin errors++; $display("FAIL auipc got %h want 102c", dut.RF1.regs[12]); end
    checks++; if (dut.RF1.regs[13] !== 32'd3)        begin errors++; $display("FAIL sub got %h want 3", dut.RF1.regs[13]); end
    checks++; if (dut.RF1.regs[14] !== 32'hF0000000) begin errors++; $display("FAIL sra got %h want f0000000", dut.RF1.regs[14]); end
    checks++; if (dut.RF1.regs[15] !== 32'h10000000) begin errors++; $display("FAIL srl got %h want 10000000", dut.RF1.regs[15]); end
    checks++; if (dut.RF1.regs[16] !== 32'd24)       begin errors++; $display("FAIL sll got %h want 18", dut.RF1.regs[16]); end
    checks++; if (dut.RF1.regs[17] !== 32'd3)        begin errors++; $display("FAIL or got %h want 3", dut.RF1.regs[17]); end
    checks++; if (dut.RF1.regs[18] !== 32'd1)        begin errors++; $display("FAIL and got %h want 1", dut.RF1.regs[18]); end
    checks++; if (dut.RF1.regs[19] !== 32'hFFFFFFFE) begin errors++; $display("FAIL xor got %h want fffffffe", dut.RF1.regs[19]); end
    checks++; if (dut.RF1.regs[20] !== 32'd1)        begin errors++; $display("FAIL slti got %h want 1", dut.RF1.regs[20]); end
    checks++; if (dut.RF1.regs[21] !== 32'd0)        begin errors++; $display("FAIL blt_taken got %h want 0", dut.RF1.regs[21]); end
    checks++; if (dut.RF1.regs[22] !== 32'd1)        begin errors++; $display("FAIL bltu_fall got %h want 1", dut.RF1.regs[22]); end
    checks++; if (dut.RF1.regs[23] !== 32'd0)        begin errors++; $display("FAIL bgeu_taken got %h want 0", dut.RF1.regs[23]); end
    checks++; if (dut.RF1.regs[24] !== 32'd0)        begin errors++; $display("FAIL bge_taken got %h want 0", dut.RF1.regs[24]); end
    checks++; if (dut.RF1.regs[25] !== 32'd120)      begin errors++; $display("FAIL jalr_link got %h want 78", dut.RF1.regs[25]); end
    checks++; if (dut.RF1.regs[27] !== 32'd0)        begin errors++; $display("FAIL jalr_skip got %h want 0", dut.RF1.regs[27]); end
    checks++; if (dut.RF1.regs[28] !== 32'd7)        begin errors++; $display("FAIL jalr_target got %h want 7", dut.RF1.regs[28]); end
    checks++; if (dut.RF1.regs[29] !== 32'd0)        begin errors++; $display("FAIL custom_nop got %h want 0", dut.RF1.regs[29]); end
    checks++; if (dut.RF1.regs[30] !== 32'd0)        begin errors++; $display("FAIL mul_nop got %h want 0", dut.RF1.regs[30]); end
  endtask

  task automatic test_reset_mid_run();
    logic all_zero;
    load_alu_prog();
    start_prog();
    step(30);
    rst_n = 1'b1;
    step(1);
    checks++; if (dut.pc !== 32'h0) begin errors++; $display("FAIL mid_reset_pc got %h want 0", dut.pc); end
    all_zero = 1'b1;
    for (int i = 0; i < 32; i++) if (dut.RF1.regs[i] !== 32'd0) all_zero = 1'b0;
    checks++; if (all_zero !== 1'b1) begin errors++; $display("FAIL mid_reset_regs got nonzero want all 0"); end
    checks++; if (dut.DATA1.mem[2] !== 32'd42) begin errors++; $display("FAIL mid_reset_dmem got %0d want 42", dut.DATA1.mem[2]); end
    rst_n = 1'b0;
    step(120);
    checks++; if (dut.RF1.regs[14] !== 32'hF0000000) begin errors++; $display("FAIL rerun_sra got %h want f0000000", dut.RF1.regs[14]); end
    checks++; if (dut.RF1.regs[19] !== 32'hFFFFFFFE) begin errors++; $display("FAIL rerun_xor got %h want fffffffe", dut.RF1.regs[19]); end
    checks++; if (dut.RF1.regs[25] !== 32'd120)      begin errors++; $display("FAIL rerun_jalr got %h want 78", dut.RF1.regs[25]); end
    checks++; if (dut.RF1.regs[28] !== 32'd7)        begin errors++; $display("FAIL rerun_x28 got %h want 7", dut.RF1.regs[28]); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_double_hazard();
    test_load_use();
    test_branch();
    test_jump_link();
    test_alu_ops();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
